// File: rtl/alu_defs_pkg.sv
// Shared RV32I decode constants and the ALU issue bundle layout.
// Used by the decode stage and by the ALU consuming alu_sel.
// No logic; constants and types only.
package alu_defs_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // alu_sel is {funct7,funct3}; these are the only selectors the ALU implements
  localparam logic [9:0] ALU_SEL_ADD = {F7_BASE, F3_ADD};
  localparam logic [9:0] ALU_SEL_SUB = {F7_ALT,  F3_ADD};
  localparam logic [9:0] ALU_SEL_SLL = {F7_BASE, F3_SLL};
  localparam logic [9:0] ALU_SEL_XOR = {F7_BASE, F3_XOR};
  localparam logic [9:0] ALU_SEL_SRL = {F7_BASE, F3_SR};
  localparam logic [9:0] ALU_SEL_SRA = {F7_ALT,  F3_SR};
  localparam logic [9:0] ALU_SEL_OR  = {F7_BASE, F3_OR};
  localparam logic [9:0] ALU_SEL_AND = {F7_BASE, F3_AND};

  typedef struct packed {
    logic [31:0] in0;
    logic [31:0] in1;
    logic [9:0]  sel;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } alu_bundle_t;

  localparam int BUNDLE_W = $bits(alu_bundle_t);

endpackage

// File: rtl/alu_decode_skid_buffer.sv
// Output register plus one-entry skid for a W-bit payload.
// Latency: 1 cycle from input transfer to out_vld.
// Backpressure: stall diverts one entry to the skid; in_rdy (registered) drops while the skid is full.
module skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic         out_vld_q, out_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic         rdy_q;
  logic [W-1:0] out_dat_q;
  logic [W-1:0] skid_dat_q;
  logic         push;
  logic         load;

  assign push = in_vld && rdy_q;
  assign load = !out_vld_q || out_rdy;

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    if (load) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d  = push;
      end
    end else if (push) begin
      skid_vld_d = 1'b1;
    end
  end

  // rdy_q resets low so nothing is accepted while reset is held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      out_dat_q  <= '0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= !skid_vld_d;
      if (load) begin
        if (skid_vld_q) begin
          out_dat_q <= skid_dat_q;
        end else if (push) begin
          out_dat_q <= in_dat;
        end
      end else if (push) begin
        skid_dat_q <= in_dat;
      end
    end
  end

  assign in_rdy  = rdy_q;
  assign out_vld = out_vld_q;
  assign out_dat = out_dat_q;

endmodule

// File: rtl/alu_decode.sv
// Decode/issue stage: RV32I R-type, I-type ALU and LUI into a registered ALU bundle.
// Latency: 1 cycle, throughput 1/cycle.
// Backpressure: out_ready low holds the bundle; one extra entry is absorbed before in_ready drops.
module alu_decode
  import alu_defs_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      alu_in0,
  output logic [31:0]      alu_in1,
  output logic [9:0]       alu_sel,
  output logic [4:0]       rd,
  output logic             wb_en,
  output logic             illegal,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic        legal;
  alu_bundle_t dec;
  alu_bundle_t out_b;
  logic [BUNDLE_W-1:0] out_dat;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    dec     = '0;
    legal   = 1'b0;
    dec.rd  = instr[11:7];
    unique case (opcode)
      OP_R: begin
        dec.in0 = rs1_data;
        dec.in1 = rs2_data;
        dec.sel = {f7, f3};
        case ({f7, f3})
          ALU_SEL_ADD, ALU_SEL_SUB, ALU_SEL_SLL, ALU_SEL_XOR,
          ALU_SEL_SRL, ALU_SEL_SRA, ALU_SEL_OR,  ALU_SEL_AND: legal = 1'b1;
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        dec.in0 = rs1_data;
        dec.in1 = {{20{instr[31]}}, instr[31:20]};
        case (f3)
          F3_ADD: begin dec.sel = ALU_SEL_ADD; legal = 1'b1; end
          F3_XOR: begin dec.sel = ALU_SEL_XOR; legal = 1'b1; end
          F3_OR:  begin dec.sel = ALU_SEL_OR;  legal = 1'b1; end
          F3_AND: begin dec.sel = ALU_SEL_AND; legal = 1'b1; end
          F3_SLL: begin
            dec.in1 = {27'b0, instr[24:20]};
            dec.sel = ALU_SEL_SLL;
            legal   = (f7 == F7_BASE);
          end
          // immediate funct7 field selects logical vs arithmetic right shift
          F3_SR: begin
            dec.in1 = {27'b0, instr[24:20]};
            dec.sel = (f7 == F7_ALT) ? ALU_SEL_SRA : ALU_SEL_SRL;
            legal   = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          F3_SLT, F3_SLTU: legal = 1'b0;
          default:         legal = 1'b0;
        endcase
      end
      OP_LUI: begin
        dec.in1 = {instr[31:12], 12'b0};
        dec.sel = ALU_SEL_ADD;
        legal   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec.in0 = '0;
      dec.in1 = '0;
      dec.sel = '0;
    end
    dec.illegal = !legal;
    dec.wb_en   = legal && (dec.rd != 5'd0);
  end

  skid_buffer #(.W(BUNDLE_W)) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_valid),
    .in_rdy  (in_ready),
    .in_dat  (dec),
    .out_vld (out_valid),
    .out_rdy (out_ready),
    .out_dat (out_dat)
  );

  assign out_b   = alu_bundle_t'(out_dat);
  assign alu_in0 = out_b.in0;
  assign alu_in1 = out_b.in1;
  assign alu_sel = out_b.sel;
  assign rd      = out_b.rd;
  assign wb_en   = out_b.wb_en;
  assign illegal = out_b.illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decoded_cnt <= '0;
      illegal_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_b.illegal) begin
        if (illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_ONE;
      end else begin
        if (decoded_cnt != '1) decoded_cnt <= decoded_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_decode.sv
// Self-checking bench for alu_decode: directed vectors, stall/reset sequences, random stream vs reference model.
module tb_alu_decode;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  typedef struct packed {
    logic [31:0] in0;
    logic [31:0] in1;
    logic [9:0]  sel;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        exp;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instr = '0;
  logic [31:0]      rs1_data = '0;
  logic [31:0]      rs2_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      alu_in0;
  logic [31:0]      alu_in1;
  logic [9:0]       alu_sel;
  logic [4:0]       rd;
  logic             wb_en;
  logic             illegal;
  logic [CNT_W-1:0] decoded_cnt;
  logic [CNT_W-1:0] illegal_cnt;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  int   m_dcnt = 0;
  int   m_icnt = 0;
  bit   stalled = 0;
  exp_t held;
  vec_t tbl[13];

  alu_decode #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_sel(alu_sel), .rd(rd),
    .wb_en(wb_en), .illegal(illegal),
    .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  function automatic exp_t got_bundle();
    return {alu_in0, alu_in1, alu_sel, rd, wb_en, illegal};
  endfunction

  // Reference: classify by ISA rules, then build the bundle.
  function automatic exp_t ref_model(logic [31:0] i, logic [31:0] r1, logic [31:0] r2);
    exp_t       e;
    bit         ok;
    logic [6:0] op, f7;
    logic [2:0] f3;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    e = '0;
    ok = 0;
    if (op == 7'h33) begin
      ok = (f7 == 7'h00 && !(f3 inside {3'd2, 3'd3})) || (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
      e.in0 = r1; e.in1 = r2; e.sel = {f7, f3};
    end else if (op == 7'h13) begin
      ok = (f3 inside {3'd0, 3'd4, 3'd6, 3'd7}) || (f3 == 3'd1 && f7 == 7'h00) ||
           (f3 == 3'd5 && f7 inside {7'h00, 7'h20});
      e.in0 = r1;
      e.in1 = (f3 inside {3'd1, 3'd5}) ? 32'(i[24:20]) : 32'($signed(i[31:20]));
      e.sel = (f3 == 3'd5) ? {f7, 3'd5} : {7'd0, f3};
    end else if (op == 7'h37) begin
      ok = 1;
      e.in1 = i & 32'hFFFF_F000;
    end
    if (!ok) e = '0;
    e.rd  = i[11:7];
    e.ill = !ok;
    e.wb  = ok && (i[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] i;
    int k;
    i = $urandom;
    k = $urandom_range(0, 9);
    if (k < 4)      i[6:0] = 7'h33;
    else if (k < 8) i[6:0] = 7'h13;
    else if (k == 8) i[6:0] = 7'h37;
    case ($urandom_range(0, 3))
      0, 1:    i[31:25] = 7'h00;
      2:       i[31:25] = 7'h20;
      default: ;
    endcase
    return i;
  endfunction

  task automatic chk(string name, logic [127:0] got, logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // One clock: check counters, hold stability, score transfers, then advance.
  task automatic cycle();
    bit   fi, fo;
    exp_t g, e;
    g  = got_bundle();
    fi = in_valid && in_ready;
    fo = out_valid && out_ready;
    chk("decoded_cnt", decoded_cnt, m_dcnt);
    chk("illegal_cnt", illegal_cnt, m_icnt);
    if (stalled) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_bundle", g, held);
    end
    if (fo) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_bundle: got %0h expected none", g);
      end else begin
        e = q.pop_front();
        chk("bundle", g, e);
      end
    end
    if (fi) q.push_back(ref_model(instr, rs1_data, rs2_data));
    stalled = out_valid && !out_ready;
    held    = g;
    @(posedge clk); #1;
    if (fo) begin
      if (g.ill) m_icnt = (m_icnt < CNT_MAX) ? m_icnt + 1 : CNT_MAX;
      else       m_dcnt = (m_dcnt < CNT_MAX) ? m_dcnt + 1 : CNT_MAX;
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_dcnt = 0; m_icnt = 0; stalled = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic apply(logic [31:0] i, logic [31:0] r1, logic [31:0] r2);
    instr = i; rs1_data = r1; rs2_data = r2;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
  endtask

  initial begin
    tbl[0]  = '{32'h002081B3, 32'd5, 32'd7, '{32'd5, 32'd7, 10'h000, 5'd3, 1'b1, 1'b0}};
    tbl[1]  = '{32'h402081B3, 32'd5, 32'd7, '{32'd5, 32'd7, 10'h100, 5'd3, 1'b1, 1'b0}};
    tbl[2]  = '{32'h40335293, 32'h80000000, 32'd0, '{32'h80000000, 32'd3, 10'h105, 5'd5, 1'b1, 1'b0}};
    tbl[3]  = '{32'hFFF00093, 32'd0, 32'd0, '{32'd0, 32'hFFFFFFFF, 10'h000, 5'd1, 1'b1, 1'b0}};
    tbl[4]  = '{32'h00000013, 32'h1234, 32'd0, '{32'h1234, 32'd0, 10'h000, 5'd0, 1'b0, 1'b0}};
    tbl[5]  = '{32'h0020A1B3, 32'd5, 32'd7, '{32'd0, 32'd0, 10'h000, 5'd3, 1'b0, 1'b1}};
    tbl[6]  = '{32'h0000007F, 32'd1, 32'd2, '{32'd0, 32'd0, 10'h000, 5'd0, 1'b0, 1'b1}};
    tbl[7]  = '{32'h123453B7, 32'd9, 32'd9, '{32'd0, 32'h12345000, 10'h000, 5'd7, 1'b1, 1'b0}};
    tbl[8]  = '{32'h00409113, 32'hF, 32'd0, '{32'hF, 32'd4, 10'h001, 5'd2, 1'b1, 1'b0}};
    tbl[9]  = '{32'h40409113, 32'hF, 32'd0, '{32'd0, 32'd0, 10'h000, 5'd2, 1'b0, 1'b1}};
    tbl[10] = '{32'h80F2F213, 32'hAAAA5555, 32'd0, '{32'hAAAA5555, 32'hFFFFF80F, 10'h007, 5'd4, 1'b1, 1'b0}};
    tbl[11] = '{32'h4020D1B3, 32'h80000000, 32'd4, '{32'h80000000, 32'd4, 10'h105, 5'd3, 1'b1, 1'b0}};
    tbl[12] = '{32'h402091B3, 32'd5, 32'd7, '{32'd0, 32'd0, 10'h000, 5'd3, 1'b0, 1'b1}};

    // reset state
    #3;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_bundle", got_bundle(), 0);
    chk("rst_dcnt", decoded_cnt, 0);
    chk("rst_icnt", illegal_cnt, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);

    // two illegal encodings bump only illegal_cnt
    apply(32'h0020A1B3, 32'd1, 32'd2);
    apply(32'h0000007F, 32'd1, 32'd2);
    chk("illegal_cnt_two", illegal_cnt, 2);
    chk("decoded_cnt_zero", decoded_cnt, 0);

    // directed table, 1-cycle latency
    for (int n = 0; n < 13; n++) begin
      instr = tbl[n].instr; rs1_data = tbl[n].rs1; rs2_data = tbl[n].rs2;
      in_valid = 1'b1; out_ready = 1'b1;
      cycle();
      in_valid = 1'b0;
      chk($sformatf("tbl%0d_valid", n), out_valid, 1);
      chk($sformatf("tbl%0d_bundle", n), got_bundle(), tbl[n].exp);
      cycle();
    end

    // 8-deep stream with a 3-cycle stall
    do_reset();
    begin
      int idx, cyc;
      bit fire;
      idx = 0;
      for (cyc = 0; cyc < 60 && (idx < 8 || q.size() != 0); cyc++) begin
        in_valid  = (idx < 8);
        instr     = {12'(idx + 1), 5'd0, 3'd0, 5'(idx + 1), 7'h13};
        rs1_data  = 32'(idx);
        out_ready = !(cyc >= 1 && cyc <= 3);
        if (cyc == 1) chk("stall_in_ready_before", in_ready, 1);
        fire = in_valid && in_ready;
        cycle();
        if (fire) idx++;
        if (cyc == 1) chk("stall_in_ready_drop", in_ready, 0);
      end
      in_valid = 1'b0;
      chk("stream_all_sent", idx, 8);
      chk("stream_drained", q.size(), 0);
      chk("stream_decoded_cnt", decoded_cnt, 8);
    end

    // reset with output register and skid both full
    in_valid = 1'b1; out_ready = 1'b0;
    instr = 32'h002081B3; rs1_data = 32'd1; rs2_data = 32'd2;
    cycle();
    cycle();
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_dcnt", decoded_cnt, 0);
    chk("midrst_icnt", illegal_cnt, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release_ready", in_ready, 1);
    instr = 32'h402081B3; rs1_data = 32'd9; rs2_data = 32'd4;
    in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("midrst_latency", out_valid, 1);
    cycle();
    chk("midrst_single", out_valid, 0);

    // random stream against the reference model, counters saturate at 15
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      instr     = rand_instr();
      rs1_data  = $urandom;
      rs2_data  = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) cycle();
    chk("random_drained", q.size(), 0);
    chk("sat_decoded", decoded_cnt, CNT_MAX);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_decode.md
Name: alu_decode

Overview:
Decode/issue stage that produces operands and the 10-bit {funct7,funct3} selector consumed by the ALU. Accepts one RV32I instruction per cycle with its already-read rs1/rs2 data over a valid/ready handshake. Decodes R-type ALU ops, I-type ALU ops and LUI, and drives a registered, back-pressurable ALU issue bundle. Flags unsupported encodings as illegal and keeps saturating decoded and illegal counters.

Parameters:
CNT_W, 16, width of the decoded_cnt and illegal_cnt saturating counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  instruction and operands valid.
in_ready  out  1  stage can accept; a transfer happens when in_valid&in_ready.
instr  in  32  RV32I instruction word.
rs1_data  in  32  register value for instr[19:15].
rs2_data  in  32  register value for instr[24:20].
out_valid  out  1  issue bundle valid.
out_ready  in  1  ALU/execute accepts; a transfer happens when out_valid&out_ready.
alu_in0  out  32  ALU operand 0.
alu_in1  out  32  ALU operand 1.
alu_sel  out  10  {funct7,funct3} ALU selector.
rd  out  5  destination register.
wb_en  out  1  write back result.
illegal  out  1  unsupported encoding.
decoded_cnt  out  CNT_W  legal bundles delivered, saturating.
illegal_cnt  out  CNT_W  illegal bundles delivered, saturating.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid empty, in_ready=0 while reset is asserted and 1 on the first cycle after release. All bundle fields and both counters are 0. Reset mid-stream discards both held entries; there is no replay.
- Decode is combinational on the input side and registered into the output stage. Latency is 1 cycle from input transfer to out_valid. Throughput is 1 per cycle.
- R-type (opcode 0110011): in0=rs1_data, in1=rs2_data, sel={funct7,funct3}.
  - Legal when funct7=0000000 and funct3 is in {000,001,100,101,110,111}.
  - Also legal when funct7=0100000 and funct3 is in {000,101}.
- I-type (opcode 0010011): in0=rs1_data.
  - funct3 000/100/110/111: in1=sign-extended instr[31:20], sel={7'b0,funct3}. addi never maps to sub.
  - funct3 001: legal only if instr[31:25]=0. in1={27'b0,instr[24:20]}, sel=10'h001.
  - funct3 101: instr[31:25] must be 0000000 or 0100000. in1={27'b0,instr[24:20]}, sel={instr[31:25],3'b101}.
- LUI (opcode 0110111): in0=0, in1={instr[31:12],12'b0}, sel=10'h000.
- All other opcodes and funct combinations are illegal, including funct3 010/011 (slt/sltu are not supported by the ALU).
  - Illegal bundle: illegal=1, wb_en=0, sel=0, in0=in1=0, rd=instr[11:7].
  - The bundle is still delivered so the downstream stage can trap.
- wb_en=1 only for a legal instruction with rd≠0.
- Handshake:
  - Output register plus one-entry skid. in_ready = !skid_valid, taken from a register.
  - If the output register is empty or out_ready=1, it loads from the skid if the skid holds an entry, otherwise from an input transfer.
  - An input transfer while the output is stalled (out_valid=1, out_ready=0) goes into the skid.
  - No entry is ever lost or duplicated; order is strictly preserved.
  - The bundle stays stable while out_valid=1 and out_ready=0.
- Counters increment on the output transfer, not on input. Both saturate at all-ones with no wrap.

Decomposition:
- Shared package/header alu_defs holds:
  - opcode constants: OP_R, OP_I, OP_LUI;
  - funct7 constants: F7_BASE, F7_ALT;
  - funct3 codes;
  - ALU_SEL_* encodings.
  The ALU consumes the same constants.
- One sub-module, skid_buffer (parameter W), holds the output register and skid for a 32+32+10+5+1+1 bit payload. Decode logic stays in alu_decode.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 -> next cycle out_valid=1, in0=5, in1=7, sel=10'h000, rd=3, wb_en=1, illegal=0.
- sub x3,x1,x2 (0x402081B3) -> sel=10'h100. srai x5,x6,3 (0x40335293), rs1=0x80000000 -> sel=10'h105, in1=3, rd=5.
- addi x1,x0,-1 (0xFFF00093) -> in1=0xFFFFFFFF, sel=10'h000, wb_en=1. addi x0,x0,0 (0x00000013) -> wb_en=0.
- slt (0x0020A1B3) and opcode 0x7F -> illegal=1, wb_en=0, sel=0; illegal_cnt 0->2, decoded_cnt unchanged.
- Stream 8 instructions with out_ready held low for 3 cycles:
  - in_ready drops one cycle after the first stalled accept.
  - All 8 bundles arrive in order with no duplicates.
  - decoded_cnt=8.
- Assert rst_n low mid-stall with both entries full -> out_valid=0 and counters=0 immediately. After release, in_ready=1 and the next instruction has 1-cycle latency.
